// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int unsigned SYS_CLK_FREQ = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                busy,
    output logic                overflow,
    output logic                tx
);

    localparam int unsigned CPB   = SYS_CLK_FREQ / BAUD_RATE;
    localparam int unsigned TW    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            full_q, full_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif
    logic [7:0]      mem_q [DEPTH];

    logic            push_ok;
    logic            pop;
    logic            bit_end;

    // Next-state, pointer and output computation
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        ovf_d     = ovf_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        pop       = 1'b0;
        push_ok   = wr_en && !full_q;
        bit_end   = (timer_q == TW'(CPB - 1));

        timer_d = bit_end ? '0 : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    tx_d      = shift_q[1];
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
            timer_d  = '0;
`ifdef UART_TX_PARITY_EN
            par_d    = ^mem_q[rd_ptr_q];
`endif
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        // A push against a full FIFO is dropped even if a pop frees a slot this edge
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end

        count_d = count_q + CW'(push_ok) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        busy_d  = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Storage array carries no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx       = tx_q;
    assign full     = full_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter inside `riscv_top`, upstream of the board `Tx` pin. It accepts bytes from the CPU/HCI side into a small FIFO and serialises them as 8N1 frames, LSB first, at a fixed baud rate. The block has one clock and free-runs from system reset, so the same unit serves the FPGA build and the simulation top-level.

## Interface
- `SYS_CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate.
  - `CPB = SYS_CLK_FREQ / BAUD_RATE` (integer division); CPB must be at least 2.
- `DEPTH_LOG2`, default 4: FIFO depth is `2**DEPTH_LOG2` entries.

- `clk  in  1`: system clock; all state changes on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `wr_en  in  1`: push request for `wr_data`.
- `wr_data  in  8`: byte to transmit.
- `full  out  1`: FIFO holds `2**DEPTH_LOG2` entries.
- `count  out  DEPTH_LOG2+1`: current FIFO occupancy; excludes the byte in the shifter.
- `busy  out  1`: high when the state is not IDLE or `count != 0`.
- `overflow  out  1`: sticky flag, set when a push is dropped; cleared only by `rst`.
- `tx  out  1`: serial line output, idle high; registered.

## Operation
- Reset values:
  - `tx` = 1
  - `full` = 0
  - `count` = 0
  - `busy` = 0
  - `overflow` = 0
  - FSM in IDLE, FIFO pointers at 0
- Push:
  - On a rising edge with `wr_en` = 1 and `full` = 0, `wr_data` is written and `count` increments.
  - On a rising edge with `wr_en` = 1 and `full` = 1, the byte is dropped and `overflow` is set. This applies even if a pop happens on the same edge.
- Pop: the FSM reads the FIFO head when it enters START.
- Simultaneous push and pop: `count` is unchanged.
- FIFO pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. `full` and empty are derived from `count`.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: `tx` = 1. If `count != 0`, pop, load the shift register, reset the bit timer, and go to START.
  - START: `tx` = 0 for CPB cycles, then go to DATA with bit index 0.
  - DATA: `tx` = `shift[0]` for CPB cycles per bit. Shift right after each bit. After bit 7, go to STOP (or PARITY).
  - STOP: `tx` = 1 for CPB cycles. At the end, if `count != 0`, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Bit timer: counts 0..CPB-1 and is sized `$clog2(CPB)` bits. Bit/state advance happens on the edge where the timer equals CPB-1; the timer then reloads to 0.
- Reset during a frame: `tx` returns to 1 asynchronously, the FIFO is emptied, and the partial frame is abandoned. After release, nothing is sent until a new push.

## Timing
- A push at edge E0 into an idle, empty block gives `count` = 1 after E0.
  - At E1 the byte is popped, `count` returns to 0 and `tx` falls.
  - Push-to-start-bit latency is 1 cycle.
- Frame length is 10·CPB cycles (11·CPB with parity). Back-to-back frames are contiguous.
- `busy` falls on the edge that ends the last stop bit.
- Capacity: a full FIFO plus the shifter means `2**DEPTH_LOG2 + 1` bytes can be accepted from idle in consecutive cycles before `full` blocks.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CPB cycles, and frames are 11·CPB cycles.
  - Undefined: no PARITY state; frames are 8N1 at 10·CPB cycles.

## Test plan
All tests use `SYS_CLK_FREQ` = 8, `BAUD_RATE` = 1 (CPB = 8) and `DEPTH_LOG2` = 4.

- **Single byte:** push 0x55 from idle.
  - `tx` falls 1 cycle later and stays low for 8 cycles.
  - Data bits follow as 1,0,1,0,1,0,1,0, 8 cycles each, then a stop bit of 1.
  - `busy` deasserts 80 cycles after `tx` fell.
- **Burst:** push 0x00, 0xFF, 0xA5 on consecutive cycles.
  - Three frames appear back-to-back over 240 cycles, with no high gap between the stop and start bits.
  - Bits decode to the same bytes in order.
- **Overflow:** push 18 bytes on consecutive cycles from idle.
  - The first 17 are accepted; `full` = 1 and `count` = 16 after the 17th.
  - The 18th is dropped and `overflow` = 1.
  - Exactly 17 frames are sent; `overflow` stays 1 after `busy` falls.
- **Reset mid-frame:** push 0xC3, then assert `rst` during data bit 3.
  - `tx` = 1 and `count` = 0 immediately.
  - After `rst` is released, `tx` stays high for 200 cycles.
- **Wrap-around:** push 16 bytes, let them drain, then push 16 more.
  - All 32 bytes are sent in order, confirming correct pointer wrap.
- **Parity** (`UART_TX_PARITY_EN` defined): push 0x07.
  - The parity bit is 1, followed by the stop bit.
  - The frame is 88 cycles long.
